beep_alarm_sched: RTL and testbench

//  Alarm scheduler in front of the beep tone generator. Arbitrates up to four

---
 rtl/beep_alarm_sched.sv | 202 ++++++++++++++++++++
 tb/tb_beep_alarm_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/beep_alarm_sched.sv
// ---------------------------------------------------------------------------
// beep_alarm_sched
// Alarm scheduler that sits in front of the beep tone generator. It picks one
// of four level alarm requests by fixed priority, with bit 3 the highest. While
// that request holds, it drives a cadence: BURSTS tone bursts separated by
// OFF_CYC silent cycles, then a GAP_CYC silent gap, and the group repeats.
// An acknowledge mutes the active alarm until its request drops.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   req[3:0]    level alarm requests, bit 3 = highest priority
//   ack         single-cycle acknowledge pulse (mutes the active alarm)
//   beep_en     tone enable, high only during bursts
//   beep_state  3-bit tone select (TONE_MAP code of active_id, 000 when idle)
//   active_id   index of the alarm being sounded
//   busy        high whenever the scheduler is not idle
//   mute[3:0]   per-requester mute flags
// ---------------------------------------------------------------------------
module beep_alarm_sched #(
    parameter int          ON_CYC   = 50,
    parameter int          OFF_CYC  = 50,
    parameter int          BURSTS   = 3,
    parameter int          GAP_CYC  = 200,
    parameter int          CNT_W    = 16,
    parameter logic [11:0] TONE_MAP = 12'o4321
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       beep_en,
    output logic [2:0] beep_state,
    output logic [1:0] active_id,
    output logic       busy,
    output logic [3:0] mute
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Index of the highest set bit; 0 when nothing is set (callers check for that).
    function automatic logic [1:0] winner_f(input logic [3:0] v);
        logic [1:0] w;
        if (v[3])      w = 2'd3;
        else if (v[2]) w = 2'd2;
        else if (v[1]) w = 2'd1;
        else           w = 2'd0;
        return w;
    endfunction

    // Tone code assigned to a requester index.
    function automatic logic [2:0] tone_f(input logic [1:0] id);
        logic [2:0] t;
        case (id)
            2'd0:    t = TONE_MAP[2:0];
            2'd1:    t = TONE_MAP[5:3];
            2'd2:    t = TONE_MAP[8:6];
            2'd3:    t = TONE_MAP[11:9];
            default: t = 3'b000;
        endcase
        return t;
    endfunction

    state_t           state_r, state_n_s;
    logic [1:0]       active_id_r, id_n_s;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic [CNT_W-1:0] burst_r, burst_n_s;
    logic [3:0]       mute_r, mute_n_s;
    logic             beep_en_r, busy_r;
    logic [2:0]       beep_state_r;

    logic [3:0]       ack_mask_s;
    logic [3:0]       elig_s;
    logic [1:0]       win_s;
    logic             active_ok_s;

    // Arbitration view: an ack in this cycle already counts as a mute, so a
    // higher request arriving with the ack can take over on the same edge.
    always_comb begin
        if ((state_r != ST_IDLE) && ack) begin
            ack_mask_s = 4'b0001 << active_id_r;
        end else begin
            ack_mask_s = 4'b0000;
        end
        elig_s      = req & ~mute_r & ~ack_mask_s;
        win_s       = winner_f(elig_s);
        active_ok_s = req[active_id_r] & ~mute_r[active_id_r];
        // A mute is only kept while its request is still present.
        mute_n_s    = (mute_r | ack_mask_s) & req;
    end

    // Next-state and counter logic.
    always_comb begin
        state_n_s = state_r;
        id_n_s    = active_id_r;
        cnt_n_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        burst_n_s = burst_r;
        case (state_r)
            ST_IDLE: begin
                cnt_n_s   = {CNT_W{1'b0}};
                burst_n_s = {CNT_W{1'b0}};
                if (elig_s != 4'b0000) begin
                    state_n_s = ST_ON;
                    id_n_s    = win_s;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            default: begin
                if (!active_ok_s) begin
                    // Active request gone: always pass through IDLE before re-arbitrating.
                    state_n_s = ST_IDLE;
                    cnt_n_s   = {CNT_W{1'b0}};
                    burst_n_s = {CNT_W{1'b0}};
                end else if ((elig_s != 4'b0000) && (win_s > active_id_r)) begin
                    state_n_s = ST_ON;
                    id_n_s    = win_s;
                    cnt_n_s   = {CNT_W{1'b0}};
                    burst_n_s = {CNT_W{1'b0}};
                end else if (ack) begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = {CNT_W{1'b0}};
                    burst_n_s = {CNT_W{1'b0}};
                end else begin
                    case (state_r)
                        ST_ON: begin
                            if (cnt_r == CNT_W'(ON_CYC - 1)) begin
                                cnt_n_s = {CNT_W{1'b0}};
                                if ((burst_r + {{(CNT_W-1){1'b0}}, 1'b1}) < CNT_W'(BURSTS)) begin
                                    state_n_s = ST_OFF;
                                end else begin
                                    state_n_s = ST_GAP;
                                    burst_n_s = {CNT_W{1'b0}};
                                end
                            end else begin
                                state_n_s = ST_ON;
                            end
                        end
                        ST_OFF: begin
                            if (cnt_r == CNT_W'(OFF_CYC - 1)) begin
                                state_n_s = ST_ON;
                                cnt_n_s   = {CNT_W{1'b0}};
                                burst_n_s = burst_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                state_n_s = ST_OFF;
                            end
                        end
                        ST_GAP: begin
                            if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
                                state_n_s = ST_ON;
                                cnt_n_s   = {CNT_W{1'b0}};
                            end else begin
                                state_n_s = ST_GAP;
                            end
                        end
                        default: begin
                            state_n_s = ST_IDLE;
                            cnt_n_s   = {CNT_W{1'b0}};
                            burst_n_s = {CNT_W{1'b0}};
                        end
                    endcase
                end
            end
        endcase
    end

    // State registers; outputs are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            active_id_r  <= 2'd0;
            cnt_r        <= {CNT_W{1'b0}};
            burst_r      <= {CNT_W{1'b0}};
            mute_r       <= 4'b0000;
            beep_en_r    <= 1'b0;
            beep_state_r <= 3'b000;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            active_id_r  <= id_n_s;
            cnt_r        <= cnt_n_s;
            burst_r      <= burst_n_s;
            mute_r       <= mute_n_s;
            beep_en_r    <= (state_n_s == ST_ON);
            beep_state_r <= (state_n_s != ST_IDLE) ? tone_f(id_n_s) : 3'b000;
            busy_r       <= (state_n_s != ST_IDLE);
        end
    end

    assign beep_en    = beep_en_r;
    assign beep_state = beep_state_r;
    assign active_id  = active_id_r;
    assign busy       = busy_r;
    assign mute       = mute_r;

endmodule

// File: tb/tb_beep_alarm_sched.sv
// ---------------------------------------------------------------------------
// tb_beep_alarm_sched
// Scoreboard bench: inputs change on the falling edge, a reference model
// steps on each rising edge and queues the expected outputs, and a monitor
// on the falling edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_beep_alarm_sched;

    localparam int ON_CYC  = 4;
    localparam int OFF_CYC = 3;
    localparam int BURSTS  = 2;
    localparam int GAP_CYC = 10;
    // One full group: bursts, the gaps between them, then the long gap.
    localparam int PERIOD  = BURSTS * ON_CYC + (BURSTS - 1) * OFF_CYC + GAP_CYC;
    localparam int TONE_SPAN = BURSTS * ON_CYC + (BURSTS - 1) * OFF_CYC;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic       beep_en;
    logic [2:0] beep_state;
    logic [1:0] active_id;
    logic       busy;
    logic [3:0] mute;

    beep_alarm_sched #(
        .ON_CYC  (ON_CYC),
        .OFF_CYC (OFF_CYC),
        .BURSTS  (BURSTS),
        .GAP_CYC (GAP_CYC),
        .CNT_W   (16),
        .TONE_MAP(12'o4321)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .beep_en   (beep_en),
        .beep_state(beep_state),
        .active_id (active_id),
        .busy      (busy),
        .mute      (mute)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] st;
        logic       busy;
        logic [3:0] mute;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;

    // Tone code for each requester as listed in TONE_MAP 12'o4321.
    int   tone_tab [4] = '{1, 2, 3, 4};

    // Reference model state: whether an alarm sounds, which one, and the
    // position within the repeating group.
    bit   m_active;
    int   m_id;
    int   m_pos;
    logic [3:0] m_mute;
    logic [3:0] m_ackm;
    int   m_h;
    exp_t m_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit tone_on(input int pos);
        return (pos < TONE_SPAN) && ((pos % (ON_CYC + OFF_CYC)) < ON_CYC);
    endfunction

    // Reference model: one step per rising edge, expected outputs queued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_id     = 0;
            m_pos    = 0;
            m_mute   = 4'b0000;
            exp_q.delete();
        end else begin
            m_ackm = 4'b0000;
            if (m_active && ack) m_ackm[m_id] = 1'b1;
            if (!m_active) begin
                m_h = highest(req & ~m_mute);
                if (m_h >= 0) begin
                    m_active = 1'b1;
                    m_id     = m_h;
                    m_pos    = 0;
                end
            end else if (!req[m_id] || m_mute[m_id]) begin
                m_active = 1'b0;
            end else begin
                m_h = highest(req & ~m_mute & ~m_ackm);
                if (m_h > m_id) begin
                    m_id  = m_h;
                    m_pos = 0;
                end else if (ack) begin
                    m_active = 1'b0;
                end else begin
                    m_pos = (m_pos + 1) % PERIOD;
                end
            end
            m_mute    = (m_mute | m_ackm) & req;
            m_e.en    = m_active && tone_on(m_pos);
            m_e.st    = m_active ? 3'(tone_tab[m_id]) : 3'b000;
            m_e.busy  = m_active;
            m_e.mute  = m_mute;
            m_e.id    = 2'(m_id);
            exp_q.push_back(m_e);
        end
    end

    // Monitor: reset values while in reset, otherwise one queued expectation per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_beep_en", int'(beep_en), 0);
            chk("rst_beep_state", int'(beep_state), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_mute", int'(mute), 0);
            chk("rst_active_id", int'(active_id), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            chk("beep_en", int'(beep_en), int'(e.en));
            chk("beep_state", int'(beep_state), int'(e.st));
            chk("busy", int'(busy), int'(e.busy));
            chk("mute", int'(mute), int'(e.mute));
            if (e.busy) chk("active_id", int'(active_id), int'(e.id));
        end
    end

    task automatic step(input logic [3:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
    endtask

    task automatic hold(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        hold(4'b0000, 20);
        // Single request: full cadence several times.
        hold(4'b0001, 50);
        hold(4'b0000, 3);
        // Preemption during OFF, then release of the higher request.
        hold(4'b0010, 6);
        hold(4'b1010, 10);
        hold(4'b0010, 10);
        hold(4'b0000, 3);
        // Acknowledge mid-burst, mute held until request drops and returns.
        hold(4'b0100, 2);
        step(4'b0100, 1'b1);
        hold(4'b0100, 10);
        hold(4'b0000, 2);
        hold(4'b0100, 10);
        hold(4'b0000, 3);
        // Acknowledge coinciding with a higher request.
        hold(4'b0001, 3);
        step(4'b1001, 1'b1);
        hold(4'b1001, 10);
        hold(4'b0000, 3);
        // Asynchronous reset in the middle of a burst.
        hold(4'b0001, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_beep_en", int'(beep_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'b0001, 30);

        // Randomised traffic: requests change occasionally, sparse acks.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            step(req, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        hold(4'b0000, 5);
        @(negedge clk);
        @(negedge clk);
        chk("monitor_pops_min", (pops >= 3000) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
